// File: rtl/pc_unit.sv
// Program counter for the single-cycle MIPS datapath: next-PC select, misaligned-target trap, halt.
// Latency: a redirect sampled at edge N appears on pc after edge N; pc_plus4/pc_hi are combinational from pc.
// Backpressure: stall freezes pc, state, bad_addr and upd_count; HALTED ignores everything except reset.
module pc_unit #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter logic [31:0] TRAP_VECTOR  = 32'h0000_0080
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        halt_req,
  input  logic        branch,
  input  logic [31:0] branch_imm,
  input  logic        jump,
  input  logic [31:0] j_target,
  input  logic        jr,
  input  logic [31:0] jr_target,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic [3:0]  pc_hi,
  output logic        halted,
  output logic        exc,
  output logic [31:0] bad_addr,
  output logic [31:0] upd_count
);

  typedef enum logic {
    RUN    = 1'b0,
    HALTED = 1'b1
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic [31:0] target;
  logic        misaligned;
  logic [31:0] pc_nxt;
  logic [31:0] bad_nxt;
  logic [31:0] cnt_nxt;
  logic        exc_nxt;

  assign pc_plus4 = pc + 32'd4;
  assign pc_hi    = pc_plus4[31:28];
  assign halted   = (state == HALTED);

  // Candidate next PC: jr beats jump beats branch beats fall-through.
  always_comb begin
    target = pc_plus4;
    if (jr) begin
      target = jr_target;
    end else if (jump) begin
      target = j_target;
    end else if (branch) begin
      target = pc_plus4 + (branch_imm << 2);
    end
  end

  // Only register/jump targets can be unaligned while pc itself is aligned.
  assign misaligned = (target[1:0] != 2'b00);

  // Next-state and next-register logic; a halt request discards that cycle's redirect.
  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    bad_nxt   = bad_addr;
    cnt_nxt   = upd_count;
    exc_nxt   = 1'b0;
    case (state)
      RUN: begin
        if (!stall) begin
          if (halt_req) begin
            state_nxt = HALTED;
          end else begin
            cnt_nxt = upd_count + 32'd1;
            if (misaligned) begin
              pc_nxt  = TRAP_VECTOR;
              bad_nxt = target;
              exc_nxt = 1'b1;
            end else begin
              pc_nxt = target;
            end
          end
        end
      end
      HALTED: begin
        state_nxt = HALTED;
      end
      default: begin
        state_nxt = RUN;
      end
    endcase
  end

  // State register; reset overrides stall, halt and any redirect.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= RUN;
      pc        <= RESET_VECTOR;
      bad_addr  <= 32'h0;
      upd_count <= 32'h0;
      exc       <= 1'b0;
    end else begin
      state     <= state_nxt;
      pc        <= pc_nxt;
      bad_addr  <= bad_nxt;
      upd_count <= cnt_nxt;
      exc       <= exc_nxt;
    end
  end

endmodule

// File: tb/tb_pc_unit.sv
// Bench for pc_unit: directed vector table, then randomized traffic against a behavioural model.
// Inputs change 1ns after the rising edge; outputs are sampled 1ns after the rising edge.
// Summary line reports vectors applied and miscompares.
module tb_pc_unit;

  localparam logic [31:0] RV = 32'h0000_0000;
  localparam logic [31:0] TV = 32'h0000_0080;

  logic        clk = 1'b0;
  logic        reset, stall, halt_req, branch, jump, jr;
  logic [31:0] branch_imm, j_target, jr_target;
  logic [31:0] pc, pc_plus4, bad_addr, upd_count;
  logic [3:0]  pc_hi;
  logic        halted, exc;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  pc_unit #(.RESET_VECTOR(RV), .TRAP_VECTOR(TV)) dut (
    .clk(clk), .reset(reset), .stall(stall), .halt_req(halt_req),
    .branch(branch), .branch_imm(branch_imm), .jump(jump), .j_target(j_target),
    .jr(jr), .jr_target(jr_target), .pc(pc), .pc_plus4(pc_plus4), .pc_hi(pc_hi),
    .halted(halted), .exc(exc), .bad_addr(bad_addr), .upd_count(upd_count)
  );

  typedef struct {
    logic        rst, stl, hlt, br;
    logic [31:0] imm;
    logic        jmp;
    logic [31:0] jt;
    logic        jrr;
    logic [31:0] jrt;
    logic [31:0] e_pc;
    logic        e_halted, e_exc;
    logic [31:0] e_bad, e_cnt;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic rst, stl, hlt, br, input logic [31:0] imm,
                     input logic jmp, input logic [31:0] jt,
                     input logic jrr, input logic [31:0] jrt,
                     input logic [31:0] e_pc, input logic e_halted, e_exc,
                     input logic [31:0] e_bad, e_cnt);
    vec_t v;
    v.rst = rst; v.stl = stl; v.hlt = hlt; v.br = br; v.imm = imm;
    v.jmp = jmp; v.jt = jt; v.jrr = jrr; v.jrt = jrt;
    v.e_pc = e_pc; v.e_halted = e_halted; v.e_exc = e_exc;
    v.e_bad = e_bad; v.e_cnt = e_cnt;
    tbl.push_back(v);
  endtask

  task automatic drive(input logic rst, stl, hlt, br, input logic [31:0] imm,
                       input logic jmp, input logic [31:0] jt,
                       input logic jrr, input logic [31:0] jrt);
    reset = rst; stall = stl; halt_req = hlt; branch = br; branch_imm = imm;
    jump = jmp; j_target = jt; jr = jrr; jr_target = jrt;
  endtask

  task automatic check(input string tag, input logic [31:0] e_pc, input logic e_halted,
                       input logic e_exc, input logic [31:0] e_bad, input logic [31:0] e_cnt);
    logic [31:0] e_p4;
    bit bad;
    e_p4 = e_pc + 32'd4;
    bad = 0;
    vectors++;
    if (pc !== e_pc) begin
      $display("FAIL %s pc: got %h want %h", tag, pc, e_pc); bad = 1;
    end
    if (pc_plus4 !== e_p4) begin
      $display("FAIL %s pc_plus4: got %h want %h", tag, pc_plus4, e_p4); bad = 1;
    end
    if (pc_hi !== e_p4[31:28]) begin
      $display("FAIL %s pc_hi: got %h want %h", tag, pc_hi, e_p4[31:28]); bad = 1;
    end
    if (halted !== e_halted) begin
      $display("FAIL %s halted: got %b want %b", tag, halted, e_halted); bad = 1;
    end
    if (exc !== e_exc) begin
      $display("FAIL %s exc: got %b want %b", tag, exc, e_exc); bad = 1;
    end
    if (bad_addr !== e_bad) begin
      $display("FAIL %s bad_addr: got %h want %h", tag, bad_addr, e_bad); bad = 1;
    end
    if (upd_count !== e_cnt) begin
      $display("FAIL %s upd_count: got %h want %h", tag, upd_count, e_cnt); bad = 1;
    end
    if (bad) miscompares++;
  endtask

  // Behavioural model state
  logic [31:0] m_pc, m_bad, m_cnt;
  logic        m_halted, m_exc;

  task automatic model_step();
    logic [31:0] tgt;
    if (reset) begin
      m_pc = RV; m_bad = 32'h0; m_cnt = 32'h0; m_halted = 1'b0; m_exc = 1'b0;
    end else if (m_halted || stall) begin
      m_exc = 1'b0;
    end else if (halt_req) begin
      m_halted = 1'b1; m_exc = 1'b0;
    end else begin
      if (jr)          tgt = jr_target;
      else if (jump)   tgt = j_target;
      else if (branch) tgt = m_pc + 32'd4 + branch_imm * 32'd4;
      else             tgt = m_pc + 32'd4;
      if (tgt % 4 != 0) begin
        m_pc = TV; m_bad = tgt; m_exc = 1'b1;
      end else begin
        m_pc = tgt; m_exc = 1'b0;
      end
      m_cnt = m_cnt + 32'd1;
    end
  endtask

  initial begin
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0);

    //   rst stl hlt br imm           jmp jt            jr jrt           e_pc          h  e  e_bad         cnt
    add(1, 0, 0, 0, 32'h0,          0, 32'h0,         0, 32'h0,        32'h0,        0, 0, 32'h0,        0);
    add(0, 0, 0, 0, 32'h0,          0, 32'h0,         0, 32'h0,        32'h4,        0, 0, 32'h0,        1);
    add(0, 0, 0, 0, 32'h0,          0, 32'h0,         0, 32'h0,        32'h8,        0, 0, 32'h0,        2);
    add(0, 0, 0, 0, 32'h0,          0, 32'h0,         0, 32'h0,        32'hC,        0, 0, 32'h0,        3);
    add(0, 0, 0, 0, 32'h0,          1, 32'h40,        0, 32'h0,        32'h40,       0, 0, 32'h0,        4);
    add(0, 0, 0, 1, 32'hFFFF_FFFC,  0, 32'h0,         0, 32'h0,        32'h34,       0, 0, 32'h0,        5);
    add(0, 0, 0, 0, 32'h0,          1, 32'h40,        0, 32'h0,        32'h40,       0, 0, 32'h0,        6);
    add(0, 0, 0, 1, 32'h3,          0, 32'h0,         0, 32'h0,        32'h50,       0, 0, 32'h0,        7);
    add(0, 0, 0, 0, 32'h0,          1, 32'h100,       0, 32'h0,        32'h100,      0, 0, 32'h0,        8);
    add(0, 0, 0, 1, 32'h5,          1, 32'h300,       1, 32'h200,      32'h200,      0, 0, 32'h0,        9);
    add(0, 0, 0, 1, 32'h5,          1, 32'h300,       0, 32'h0,        32'h300,      0, 0, 32'h0,        10);
    add(0, 0, 0, 0, 32'h0,          0, 32'h0,         1, 32'h1002,     32'h80,       0, 1, 32'h1002,     11);
    add(0, 0, 0, 0, 32'h0,          0, 32'h0,         0, 32'h0,        32'h84,       0, 0, 32'h1002,     12);
    add(0, 0, 0, 0, 32'h0,          1, 32'hFFFF_FFFC, 0, 32'h0,        32'hFFFF_FFFC,0, 0, 32'h1002,     13);
    add(0, 1, 0, 0, 32'h0,          1, 32'h400,       0, 32'h0,        32'hFFFF_FFFC,0, 0, 32'h1002,     13);
    add(0, 1, 0, 0, 32'h0,          1, 32'h400,       0, 32'h0,        32'hFFFF_FFFC,0, 0, 32'h1002,     13);
    add(0, 0, 0, 0, 32'h0,          0, 32'h0,         0, 32'h0,        32'h0,        0, 0, 32'h1002,     14);
    add(0, 0, 0, 0, 32'h0,          1, 32'h20,        0, 32'h0,        32'h20,       0, 0, 32'h1002,     15);
    add(0, 0, 1, 0, 32'h0,          1, 32'h400,       0, 32'h0,        32'h20,       1, 0, 32'h1002,     15);
    for (int i = 0; i < 5; i++)
      add(0, 0, 0, 1, 32'h7,        1, 32'h500,       1, 32'h3,        32'h20,       1, 0, 32'h1002,     15);
    add(1, 1, 1, 0, 32'h0,          1, 32'h500,       0, 32'h0,        32'h0,        0, 0, 32'h0,        0);
    add(0, 1, 1, 0, 32'h0,          0, 32'h0,         0, 32'h0,        32'h0,        0, 0, 32'h0,        0);
    add(0, 0, 0, 0, 32'h0,          0, 32'h0,         0, 32'h0,        32'h4,        0, 0, 32'h0,        1);
    add(0, 0, 1, 0, 32'h0,          0, 32'h0,         1, 32'h1002,     32'h4,        1, 0, 32'h0,        1);
    add(1, 0, 0, 0, 32'h0,          0, 32'h0,         0, 32'h0,        32'h0,        0, 0, 32'h0,        0);

    @(negedge clk);
    foreach (tbl[i]) begin
      drive(tbl[i].rst, tbl[i].stl, tbl[i].hlt, tbl[i].br, tbl[i].imm,
            tbl[i].jmp, tbl[i].jt, tbl[i].jrr, tbl[i].jrt);
      @(posedge clk);
      #1;
      check($sformatf("dir%0d", i), tbl[i].e_pc, tbl[i].e_halted, tbl[i].e_exc,
            tbl[i].e_bad, tbl[i].e_cnt);
    end

    // Back-to-back misaligned jumps: exc stays high, bad_addr follows the latest target.
    drive(0, 0, 0, 0, 0, 1, 32'h0000_0301, 0, 0);
    @(posedge clk); #1;
    check("trap_a", TV, 0, 1, 32'h301, 1);
    drive(0, 0, 0, 0, 0, 0, 0, 1, 32'h0000_0703);
    @(posedge clk); #1;
    check("trap_b", TV, 0, 1, 32'h703, 2);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(posedge clk); #1;
    check("trap_end", TV + 32'd4, 0, 0, 32'h703, 3);

    // Randomized traffic against the behavioural model
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
    model_step();
    @(posedge clk); #1;
    check("rnd_rst", m_pc, m_halted, m_exc, m_bad, m_cnt);
    for (int n = 0; n < 3000; n++) begin
      logic [31:0] jt, jrt;
      jt  = $urandom;
      jrt = $urandom;
      if ($urandom_range(3) != 0) jt[1:0] = 2'b00;
      if ($urandom_range(3) != 0) jrt[1:0] = 2'b00;
      drive($urandom_range(63) == 0, $urandom_range(7) == 0, $urandom_range(31) == 0,
            $urandom_range(3) == 0, $urandom, $urandom_range(3) == 0, jt,
            $urandom_range(3) == 0, jrt);
      model_step();
      @(posedge clk); #1;
      check($sformatf("rnd%0d", n), m_pc, m_halted, m_exc, m_bad, m_cnt);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
